// File: rtl/ex_issue.sv
// Two-stage execute issue: S1 registers operands and ALU select, S2 captures the ALU result.
// Optional operand forwarding from S1/S2 at acceptance is enabled by defining EX_BYPASS_EN.
module ex_issue #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            op_imm,
    output logic [XLEN-1:0] data1,
    output logic [XLEN-1:0] data2,
    output logic [2:0]      alu_sel,
    input  logic [XLEN-1:0] alu_c,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    logic            s1_valid_q;
    logic [XLEN-1:0] data1_q, data2_q;
    logic [2:0]      alu_sel_q;
    logic [4:0]      s1_rd_q;
    logic            s1_illegal_q;

    logic            out_valid_q;
    logic [XLEN-1:0] out_result_q;
    logic [4:0]      out_rd_q;
    logic            out_illegal_q;

    logic            s1_adv;
    logic            accept;
    logic [2:0]      sel_d;
    logic            illegal_d;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] op2_d;
    logic [XLEN-1:0] result_d;

    assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sel_d     = 3'd0;
        illegal_d = 1'b0;
        case (funct3)
            3'b000:  sel_d = (!op_imm && funct7b5) ? 3'd1 : 3'd0;
            3'b111:  sel_d = 3'd2;
            3'b110:  sel_d = 3'd3;
            3'b100:  sel_d = 3'd4;
            3'b001:  sel_d = 3'd5;
            3'b101:  sel_d = funct7b5 ? 3'd7 : 3'd6;
            default: illegal_d = 1'b1;
        endcase
    end

`ifdef EX_BYPASS_EN
    // The younger producer in S1 wins over the older one waiting in S2.
    always_comb begin
        rs1_val = rs1_data;
        if (s1_valid_q && !s1_illegal_q && (s1_rd_q == rs1_idx) && (rs1_idx != 5'd0)) begin
            rs1_val = alu_c;
        end else if (out_valid_q && (out_rd_q == rs1_idx) && (rs1_idx != 5'd0)) begin
            rs1_val = out_result_q;
        end
        rs2_val = rs2_data;
        if (s1_valid_q && !s1_illegal_q && (s1_rd_q == rs2_idx) && (rs2_idx != 5'd0)) begin
            rs2_val = alu_c;
        end else if (out_valid_q && (out_rd_q == rs2_idx) && (rs2_idx != 5'd0)) begin
            rs2_val = out_result_q;
        end
    end
`else
    logic unused_idx;
    assign unused_idx = ^{rs1_idx, rs2_idx};
    assign rs1_val    = rs1_data;
    assign rs2_val    = rs2_data;
`endif

    assign op2_d    = op_imm ? imm : rs2_val;
    assign result_d = s1_illegal_q ? '0 : alu_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            data1_q      <= '0;
            data2_q      <= '0;
            alu_sel_q    <= 3'd0;
            s1_rd_q      <= 5'd0;
            s1_illegal_q <= 1'b0;
        end else if (accept) begin
            s1_valid_q   <= 1'b1;
            data1_q      <= rs1_val;
            data2_q      <= op2_d;
            alu_sel_q    <= sel_d;
            s1_rd_q      <= rd;
            s1_illegal_q <= illegal_d;
        end else if (s1_adv) begin
            s1_valid_q   <= 1'b0;
        end
    end

    // S2 only reloads when empty or popping, so a stalled result never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= 5'd0;
            out_illegal_q <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= result_d;
            out_rd_q      <= s1_rd_q;
            out_illegal_q <= s1_illegal_q;
        end else if (out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign data1       = data1_q;
    assign data2       = data2_q;
    assign alu_sel     = alu_sel_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_ex_issue.sv
// Bench for ex_issue: models the external ALU, scoreboards results against an ISA reference.
// Bypass expectations follow EX_BYPASS_EN when it is defined for the build.
module tb_ex_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0;
    logic [4:0]  rs1_idx = '0, rs2_idx = '0, rd = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0, op_imm = 1'b0;
    logic [31:0] data1, data2, alu_c;
    logic [2:0]  alu_sel;
    logic        out_valid, out_illegal;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ex_issue #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd(rd),
        .funct3(funct3), .funct7b5(funct7b5), .op_imm(op_imm),
        .data1(data1), .data2(data2), .alu_sel(alu_sel), .alu_c(alu_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // External combinational ALU driven by the DUT.
    always_comb begin
        case (alu_sel)
            3'd0:    alu_c = data1 + data2;
            3'd1:    alu_c = data1 - data2;
            3'd2:    alu_c = data1 & data2;
            3'd3:    alu_c = data1 | data2;
            3'd4:    alu_c = data1 ^ data2;
            3'd5:    alu_c = data1 << data2[4:0];
            3'd6:    alu_c = data1 >> data2[4:0];
            default: alu_c = $unsigned($signed(data1) >>> data2[4:0]);
        endcase
    end

    function automatic exp_t ref_exec(input logic [2:0] f3, input logic f7, input logic oi,
                                      input logic [31:0] a, input logic [31:0] b_reg,
                                      input logic [31:0] imm_v, input logic [4:0] rd_v);
        exp_t        e;
        logic [31:0] b;
        b     = oi ? imm_v : b_reg;
        e.rd  = rd_v;
        e.ill = 1'b0;
        case (f3)
            3'b000:  e.res = (!oi && f7) ? a - b : a + b;
            3'b111:  e.res = a & b;
            3'b110:  e.res = a | b;
            3'b100:  e.res = a ^ b;
            3'b001:  e.res = a << b[4:0];
            3'b101:  e.res = f7 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            default: begin e.res = '0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output result=%h rd=%0d", out_result, out_rd);
            end else begin
                e = sb.pop_front();
                if ({out_result, out_rd, out_illegal} !== {e.res, e.rd, e.ill}) begin
                    errors++;
                    $display("FAIL result got=%h/%0d/%b want=%h/%0d/%b",
                             out_result, out_rd, out_illegal, e.res, e.rd, e.ill);
                end
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic f7, input logic oi,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] i1, input logic [4:0] i2, input logic [4:0] d,
                         input logic [31:0] model_a);
        int n = 0;
        funct3 = f3; funct7b5 = f7; op_imm = oi;
        rs1_data = a; rs2_data = b; imm = im;
        rs1_idx = i1; rs2_idx = i2; rd = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL issue_timeout in_ready=%b want=1", in_ready);
        end else begin
            sb.push_back(ref_exec(f3, f7, oi, model_a, b, im, d));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, out_illegal, out_result, out_rd, data1, data2, alu_sel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b i=%b r=%h rd=%0d d1=%h d2=%h sel=%0d want 0",
                     out_valid, out_illegal, out_result, out_rd, data1, data2, alu_sel);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd9, 32'd5);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_latency_early out_valid=%b want=0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_result, out_illegal} !== {1'b1, 32'd12, 1'b0}) begin
            errors++;
            $display("FAIL add_result got v=%b r=%h i=%b want v=1 r=0000000c i=0",
                     out_valid, out_result, out_illegal);
        end
        wait_drain();
    endtask

    task automatic test_sra();
        issue(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'd4, 5'd1, 5'd0, 5'd5, 32'h8000_0000);
        checks++;
        if ({alu_sel, data1, data2} !== {3'd7, 32'h8000_0000, 32'd4}) begin
            errors++;
            $display("FAIL sra_s1 got sel=%0d d1=%h d2=%h want sel=7 d1=80000000 d2=4",
                     alu_sel, data1, data2);
        end
        @(posedge clk); #1;
        checks++;
        if (out_result !== 32'hF800_0000) begin
            errors++;
            $display("FAIL sra_result got=%h want=f8000000", out_result);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        out_ready = 1'b0;
        issue(3'b000, 1'b0, 1'b0, 32'd10, 32'd20, 32'd0, 5'd0, 5'd0, 5'd1, 32'd10);
        issue(3'b000, 1'b1, 1'b0, 32'd50, 32'd8, 32'd0, 5'd0, 5'd0, 5'd2, 32'd50);
        funct3 = 3'b100; funct7b5 = 1'b0; op_imm = 1'b0;
        rs1_data = 32'hFF; rs2_data = 32'h0F; rd = 5'd3;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_result, out_rd} !== {1'b0, 1'b1, 32'd30, 5'd1}) begin
                errors++;
                $display("FAIL stall_hold got rdy=%b v=%b r=%h rd=%0d want rdy=0 v=1 r=1e rd=1",
                         in_ready, out_valid, out_result, out_rd);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL b2b_resume in_ready=%b want=1", in_ready);
        end else begin
            sb.push_back(ref_exec(3'b100, 1'b0, 1'b0, 32'hFF, 32'h0F, 32'h0, 5'd3));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        issue(3'b010, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0, 5'd0, 5'd0, 5'd7, 32'd5);
        checks++;
        if (alu_sel !== 3'd0) begin
            errors++;
            $display("FAIL illegal_sel got=%0d want=0", alu_sel);
        end
        issue(3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 5'd0, 5'd0, 5'd8, 32'd3);
        checks++;
        if ({out_valid, out_illegal, out_result} !== {1'b1, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL illegal_out got v=%b i=%b r=%h want v=1 i=1 r=0",
                     out_valid, out_illegal, out_result);
        end
        wait_drain();
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        issue(3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd0, 5'd0, 5'd3, 32'd1);
`ifdef EX_BYPASS_EN
        issue(3'b000, 1'b0, 1'b1, 32'd0, 32'd0, 32'd10, 5'd3, 5'd0, 5'd4, 32'd3);
`else
        issue(3'b000, 1'b0, 1'b1, 32'd0, 32'd0, 32'd10, 5'd3, 5'd0, 5'd4, 32'd0);
`endif
        // rd=0 producer must never be forwarded.
        issue(3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd0, 5'd0, 5'd0, 32'd1);
        issue(3'b000, 1'b0, 1'b1, 32'd100, 32'd0, 32'd1, 5'd0, 5'd0, 5'd5, 32'd100);
        wait_drain();
        issue(3'b000, 1'b0, 1'b0, 32'd4, 32'd5, 32'd0, 5'd0, 5'd0, 5'd6, 32'd4);
        issue(3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd0, 5'd0, 5'd7, 32'd1);
`ifdef EX_BYPASS_EN
        issue(3'b000, 1'b0, 1'b1, 32'd0, 32'd0, 32'd1, 5'd6, 5'd0, 5'd8, 32'd9);
`else
        issue(3'b000, 1'b0, 1'b1, 32'd0, 32'd0, 32'd1, 5'd6, 5'd0, 5'd8, 32'd0);
`endif
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        issue(3'b000, 1'b0, 1'b0, 32'd11, 32'd22, 32'd0, 5'd0, 5'd0, 5'd1, 32'd11);
        issue(3'b110, 1'b0, 1'b0, 32'hF0, 32'h0F, 32'd0, 5'd0, 5'd0, 5'd2, 32'hF0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_result, data1, alu_sel} !== '0) begin
            errors++;
            $display("FAIL reset_async got v=%b r=%h d1=%h sel=%0d want 0",
                     out_valid, out_result, data1, alu_sel);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b want=1", in_ready);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush out_valid=%b want=0", out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sra();
        test_back_to_back();
        test_illegal();
        test_bypass();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
